// File: rtl/pixel_line_reorder.sv
// pixel_line_reorder: scatters out-of-order (x, depth) FIFO words into a line buffer and streams raster-order RGB pixels.
module pixel_line_reorder #(
  parameter int X_WIDTH    = 10,
  parameter int ITER_WIDTH = 10,
  parameter int LINE_WIDTH = 640,
  parameter int LINE_COUNT = 480,
  parameter int MAX_ITER   = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [X_WIDTH+ITER_WIDTH-1:0] fifo_dout,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [23:0]                   m_tdata,
  output logic                          m_tlast,
  output logic                          m_tuser,
  output logic                          frame_done,
  output logic                          oor_err
);
  localparam int XW = LINE_WIDTH > 1 ? $clog2(LINE_WIDTH) : 1;
  localparam int YW = LINE_COUNT > 1 ? $clog2(LINE_COUNT) : 1;
  localparam logic [XW-1:0] LAST_X = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(LINE_COUNT - 1);
  logic [ITER_WIDTH-1:0] mem [LINE_WIDTH];
  logic [LINE_WIDTH-1:0] valid, valid_n;
  logic [X_WIDTH+ITER_WIDTH-1:0] hold;
  logic hold_valid, rd_inflight, eof, oor, commit, load;
  logic [XW-1:0] out_x, hx;
  logic [YW-1:0] out_y;
  logic [ITER_WIDTH-1:0] hd, od;
  logic [7:0] v;
  assign hx = hold[ITER_WIDTH +: XW];
  assign hd = hold[ITER_WIDTH-1:0];
  assign od = mem[out_x];
  assign v = od[ITER_WIDTH-1 -: 8];
  assign oor = hold_valid && 32'(hold[ITER_WIDTH +: X_WIDTH]) >= LINE_WIDTH;
  assign commit = hold_valid && !oor && !valid[hx];
  assign load = valid[out_x] && (!m_tvalid || m_tready);
  assign fifo_rd_en = !fifo_empty && !rd_inflight && !hold_valid;
  // emit clears before commit sets, so a same-index refill survives
  always_comb begin
    valid_n = valid;
    if (load) valid_n[out_x] = 1'b0;
    if (commit) valid_n[hx] = 1'b1;
  end
  always_ff @(posedge clk) if (commit) mem[hx] <= hd;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      rd_inflight <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      eof         <= 1'b0;
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      m_tlast     <= 1'b0;
      m_tuser     <= 1'b0;
      frame_done  <= 1'b0;
      oor_err     <= 1'b0;
    end else begin
      rd_inflight <= fifo_rd_en;
      if (rd_inflight) begin
        hold       <= fifo_dout;
        hold_valid <= 1'b1;
      end else if (commit || oor) hold_valid <= 1'b0;
      if (oor) oor_err <= 1'b1;
      valid <= valid_n;
      if (load) begin
        m_tvalid <= 1'b1;
        m_tdata  <= od == ITER_WIDTH'(MAX_ITER) ? 24'h000000 : {v, v, ~v};
        m_tlast  <= out_x == LAST_X;
        m_tuser  <= out_x == '0 && out_y == '0;
        eof      <= out_x == LAST_X && out_y == LAST_Y;
        out_x    <= out_x == LAST_X ? '0 : out_x + 1'b1;
        if (out_x == LAST_X) out_y <= out_y == LAST_Y ? '0 : out_y + 1'b1;
      end else if (m_tready) m_tvalid <= 1'b0;
      frame_done <= m_tvalid && m_tready && m_tlast && eof;
    end
  end
endmodule
